tt_equiv_checker: RTL
=====================

Name: tt_equiv_checker

Overview:
- Sequential truth-table checker for small combinational gate modules: it drives every input pattern in minterm order to two devices under test (DUTs).
- DUT "a" is the gate-level description and DUT "b" is the expression-level description of the same function.
- It samples both DUT responses and compares each against a golden truth table held as a parameter.
- It replaces the hand-written stimulus/monitor benches: run it once per function, then read pass, fail mask, mismatch count and first failing minterm.

Parameters:
- N_IN, 2, number of DUT inputs; minterm count M = 2**N_IN.
- EXPECT, 4'b0010, golden truth table, M bits wide; bit m is the expected output for minterm m (default is a'.b).
- SETTLE, 1, wait cycles between driving a pattern and sampling the responses; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a full sweep; sampled only in IDLE or DONE.
- stim  output  N_IN  pattern driven to both DUTs; MSB is the first DUT input.
- resp_a  input  1  response of DUT a (gate form).
- resp_b  input  1  response of DUT b (expression form).
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; results valid; held until the next accepted start or reset.
- pass  output  1  1 when done and no minterm failed.
- fail_mask  output  M  bit m set if resp_a or resp_b differed from EXPECT[m].
- mismatch_cnt  output  N_IN+1  number of failing minterms.
- first_fail  output  N_IN  lowest failing minterm; valid when fail_valid=1.
- fail_valid  output  1  at least one minterm has failed.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low on rst_n. A low rst_n at a rising edge forces IDLE, and every output to 0: stim, busy, done, pass, fail_mask, mismatch_cnt, first_fail, fail_valid.
- Reset mid-sweep: the sweep is aborted and no partial results are retained.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE or DONE with start=1 at an edge:
  - go to SETTLE; stim<=0; busy<=1; done<=0; pass<=0.
  - clear fail_mask, mismatch_cnt, first_fail and fail_valid.
  - load the wait counter with SETTLE-1.
- SETTLE: decrement the wait counter each cycle; when it reaches 0, go to SAMPLE on the next edge.
- SAMPLE (exactly 1 cycle), at its edge:
  - err = (resp_a != EXPECT[stim]) OR (resp_b != EXPECT[stim]).
  - If err: set fail_mask[stim] and increment mismatch_cnt. If fail_valid was 0, capture first_fail<=stim and set fail_valid<=1.
  - If stim == M-1: go to DONE; busy<=0; done<=1; pass<=~(any error in this sweep, including the current sample).
  - Otherwise: stim<=stim+1, reload the wait counter, return to SETTLE.
- Latency: each minterm takes SETTLE+1 cycles. done rises M*(SETTLE+1) edges after the start-accept edge (defaults: 8 edges).
- stim holds its last value (M-1) in DONE.
- start while busy is ignored.
- start and rst_n low at the same edge: reset wins.
- mismatch_cnt width N_IN+1 holds the maximum value M without wrap.
- The DUTs are purely combinational, so SETTLE=1 is sufficient. A larger SETTLE is for registered or delayed DUT paths.

Optional Feature:
- Macro TT_CHK_STOP_ON_FAIL_EN.
- When defined: the first SAMPLE with err=1 ends the sweep immediately. The FSM goes to DONE with done=1 and pass=0. fail_mask has exactly one bit set, mismatch_cnt=1, and stim holds the failing minterm.
- When undefined: the sweep always covers all M minterms as described above.

Decomposition:
- Package tt_chk_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE);
  - the wait-counter width constant (4 bits);
  - function exp_bit(table, m) returning the golden bit.
- Sub-module tt_settle_timer: loadable down-counter with a zero flag, instantiated once. All other logic stays in tt_equiv_checker.

Test Plan:
- Defaults; resp_a=resp_b=~stim[1]&stim[0]; pulse start -> done=1 at edge 8, pass=1, fail_mask=4'b0000, mismatch_cnt=0, fail_valid=0.
- Defaults; resp_a=a'.b, resp_b=stim[1]^stim[0] -> minterm 2 fails: fail_mask=4'b0100, mismatch_cnt=1, first_fail=2'b10, pass=0.
- Defaults; resp_a and resp_b both stuck at 1 -> fail_mask=4'b1101, mismatch_cnt=3, first_fail=2'b00.
- SETTLE=3 with a correct DUT; start pulses while busy -> done at edge 16 after accept; the extra starts have no effect; a second start in DONE reruns with the results cleared.
- Reset asserted at edge 5 of a failing sweep -> all outputs 0, state IDLE; the next start gives full fresh results.
- With TT_CHK_STOP_ON_FAIL_EN, XOR on resp_b -> done at edge 6, stim=2'b10, mismatch_cnt=1, pass=0.

Source files
------------

// File: rtl/tt_chk_pkg.sv
// tt_chk_pkg: FSM states, wait-counter width and golden-table lookup for tt_equiv_checker
package tt_chk_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;
    localparam int CNT_W = 4;
    localparam int MAX_M = 256;
    function automatic logic exp_bit(input logic [MAX_M-1:0] tbl, input logic [7:0] m);
        return tbl[m];
    endfunction
endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: loadable down-counter that stops at zero and flags it
module tt_settle_timer
    import tt_chk_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk)
        if (!rst_n) cnt <= '0;
        else        cnt <= load ? load_val : (dec && cnt != '0) ? cnt - 1'b1 : cnt;
    assign zero = cnt == '0;
endmodule

// File: rtl/tt_equiv_checker.sv
// tt_equiv_checker: sweeps all minterms into two DUTs and checks both against a golden table
// Optional macro TT_CHK_STOP_ON_FAIL_EN ends the sweep at the first failing minterm.
module tt_equiv_checker
    import tt_chk_pkg::*;
#(
    parameter int                      N_IN   = 2,
    parameter logic [(2**N_IN)-1:0]    EXPECT = 4'b0010,
    parameter int                      SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [N_IN-1:0]       stim,
    input  logic                  resp_a,
    input  logic                  resp_b,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [(2**N_IN)-1:0]  fail_mask,
    output logic [N_IN:0]         mismatch_cnt,
    output logic [N_IN-1:0]       first_fail,
    output logic                  fail_valid
);
    localparam int M = 2**N_IN;
`ifdef TT_CHK_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif
    state_t            state, state_d;
    logic [N_IN-1:0]   stim_d, first_d;
    logic [M-1:0]      mask_d;
    logic [N_IN:0]     cnt_d;
    logic              busy_d, done_d, pass_d, fv_d;
    logic              exp_m, err, last, stop, load, dec, zero;
    tt_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (CNT_W'(SETTLE - 1)),
        .dec      (dec),
        .zero     (zero)
    );
    assign exp_m = exp_bit(MAX_M'(EXPECT), 8'(stim));
    assign err   = (resp_a != exp_m) || (resp_b != exp_m);
    assign last  = stim == N_IN'(M - 1);
    assign stop  = last || (STOP_ON_FAIL && err);
    always_comb begin
        state_d = state;
        stim_d  = stim;
        busy_d  = busy;
        done_d  = done;
        pass_d  = pass;
        mask_d  = fail_mask;
        cnt_d   = mismatch_cnt;
        first_d = first_fail;
        fv_d    = fail_valid;
        load    = 1'b0;
        dec     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: if (start) begin
                state_d = ST_SETTLE;
                stim_d  = '0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                pass_d  = 1'b0;
                mask_d  = '0;
                cnt_d   = '0;
                first_d = '0;
                fv_d    = 1'b0;
                load    = 1'b1;
            end
            ST_SETTLE: begin
                dec = 1'b1;
                if (zero) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (err) begin
                    mask_d[stim] = 1'b1;
                    cnt_d        = mismatch_cnt + 1'b1;
                    if (!fail_valid) begin
                        first_d = stim;
                        fv_d    = 1'b1;
                    end
                end
                if (stop) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = !(fail_valid || err);
                end else begin
                    state_d = ST_SETTLE;
                    stim_d  = stim + 1'b1;
                    load    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (!rst_n) begin
            state        <= ST_IDLE;
            stim         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail_mask    <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            fail_valid   <= 1'b0;
        end else begin
            state        <= state_d;
            stim         <= stim_d;
            busy         <= busy_d;
            done         <= done_d;
            pass         <= pass_d;
            fail_mask    <= mask_d;
            mismatch_cnt <= cnt_d;
            first_fail   <= first_d;
            fail_valid   <= fv_d;
        end
endmodule
